// File: rtl/alu_wb_pkg.sv
// Shared types and defaults for the ALU writeback queue.
// Optional sticky status flags are enabled by defining ALU_WB_STICKY_FLAGS_EN.
package alu_wb_pkg;

   localparam int ALU_WB_DEPTH_DEF = 4;
   localparam int ALU_WB_TAG_W_DEF = 5;
   // Tag field in the stored entry is sized for the widest supported TAG_W; narrower tags are zero-extended.
   localparam int ALU_WB_TAG_MAX_W = 16;

   typedef struct packed {
      logic [31:0]                 result;
      logic                        zero;
      logic                        cout;
      logic                        overflow;
      logic [ALU_WB_TAG_MAX_W-1:0] tag;
   } alu_wb_entry_t;

endpackage

// File: rtl/alu_wb_ram.sv
// Entry storage for the ALU writeback queue: one write port, one asynchronous read port.
// Contents are intentionally not reset; occupancy is tracked by the queue control.
module alu_wb_ram
   import alu_wb_pkg::*;
#(
   parameter int DEPTH = ALU_WB_DEPTH_DEF,
   parameter int AW    = $clog2(DEPTH)
)(
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  alu_wb_entry_t i_wdata,
   input  logic [AW-1:0] i_raddr,
   output alu_wb_entry_t o_rdata
);

   alu_wb_entry_t r_mem [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_wb_queue.sv
// FIFO between the ALU stage and writeback holding result, flags and destination tag.
// Sticky overflow/carry status is compiled in only when ALU_WB_STICKY_FLAGS_EN is defined.
module alu_wb_queue
   import alu_wb_pkg::*;
#(
   parameter int DEPTH = ALU_WB_DEPTH_DEF,
   parameter int TAG_W = ALU_WB_TAG_W_DEF
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_result,
   input  logic                       in_zero,
   input  logic                       in_cout,
   input  logic                       in_overflow,
   input  logic [TAG_W-1:0]           in_tag,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_result,
   output logic                       out_zero,
   output logic                       out_cout,
   output logic                       out_overflow,
   output logic [TAG_W-1:0]           out_tag,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       sticky_ovf,
   output logic                       sticky_cout,
   input  logic                       sticky_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;

   logic          w_push;
   logic          w_pop;
   logic          w_in_ready;
   logic          w_out_valid;
   alu_wb_entry_t w_wr_entry;
   alu_wb_entry_t w_head;

   // in_ready depends only on the registered count, never on out_ready
   assign w_in_ready  = (r_count != FULL_CNT);
   assign w_out_valid = (r_count != CW'(0));
   assign w_push      = in_valid & w_in_ready;
   assign w_pop       = w_out_valid & out_ready;

   // Pack the incoming fields into a storage entry
   always_comb begin
      w_wr_entry               = '0;
      w_wr_entry.result        = in_result;
      w_wr_entry.zero          = in_zero;
      w_wr_entry.cout          = in_cout;
      w_wr_entry.overflow      = in_overflow;
      w_wr_entry.tag[TAG_W-1:0] = in_tag;
   end

   // Pointer and occupancy tracking
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   alu_wb_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wptr),
      .i_wdata (w_wr_entry),
      .i_raddr (r_rptr),
      .o_rdata (w_head)
   );

   assign in_ready     = w_in_ready;
   assign out_valid    = w_out_valid;
   assign count        = r_count;
   assign out_result   = w_head.result;
   assign out_zero     = w_head.zero;
   assign out_cout     = w_head.cout;
   assign out_overflow = w_head.overflow;
   assign out_tag      = w_head.tag[TAG_W-1:0];

`ifdef ALU_WB_STICKY_FLAGS_EN
   logic r_sticky_ovf;
   logic r_sticky_cout;
   logic w_unused_bits;

   // A set in the same cycle as a clear wins
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sticky_ovf  <= 1'b0;
         r_sticky_cout <= 1'b0;
      end else begin
         if (w_push & in_overflow) begin
            r_sticky_ovf <= 1'b1;
         end else if (sticky_clr) begin
            r_sticky_ovf <= 1'b0;
         end
         if (w_push & in_cout) begin
            r_sticky_cout <= 1'b1;
         end else if (sticky_clr) begin
            r_sticky_cout <= 1'b0;
         end
      end
   end

   assign sticky_ovf    = r_sticky_ovf;
   assign sticky_cout   = r_sticky_cout;
   assign w_unused_bits = ^w_head.tag;
`else
   logic w_unused_bits;

   assign sticky_ovf    = 1'b0;
   assign sticky_cout   = 1'b0;
   assign w_unused_bits = ^{w_head.tag, sticky_clr};
`endif

endmodule

// File: tb/tb_alu_wb_queue.sv
// Randomized self-checking bench for alu_wb_queue against a queue-based reference model.
module tb_alu_wb_queue;

   localparam int DEPTH = 4;
   localparam int TAG_W = 5;
   localparam int EW    = 32 + 3 + TAG_W;
`ifdef ALU_WB_STICKY_FLAGS_EN
   localparam bit STICKY_EN = 1'b1;
`else
   localparam bit STICKY_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_result;
   logic             in_zero;
   logic             in_cout;
   logic             in_overflow;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_result;
   logic             out_zero;
   logic             out_cout;
   logic             out_overflow;
   logic [TAG_W-1:0] out_tag;
   logic [2:0]       count;
   logic             sticky_ovf;
   logic             sticky_cout;
   logic             sticky_clr;

   int n_chk = 0;
   int n_err = 0;

   logic [EW-1:0] m_q[$];
   logic          m_ovf  = 1'b0;
   logic          m_cout = 1'b0;

   always #5 clk = ~clk;

   alu_wb_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_result    (in_result),
      .in_zero      (in_zero),
      .in_cout      (in_cout),
      .in_overflow  (in_overflow),
      .in_tag       (in_tag),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_zero     (out_zero),
      .out_cout     (out_cout),
      .out_overflow (out_overflow),
      .out_tag      (out_tag),
      .count        (count),
      .sticky_ovf   (sticky_ovf),
      .sticky_cout  (sticky_cout),
      .sticky_clr   (sticky_clr)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, compare outputs with the model mid-cycle, then advance the model.
   task automatic cycle(input logic v, input logic [31:0] res, input logic [2:0] zco,
                        input logic [TAG_W-1:0] tg, input logic ordy, input logic clr,
                        input logic rstn);
      logic mpush;
      logic mpop;
      in_valid  = v;
      in_result = res;
      {in_zero, in_cout, in_overflow} = zco;
      in_tag     = tg;
      out_ready  = ordy;
      sticky_clr = clr;
      rst_n      = rstn;
      @(negedge clk);
      check_eq("in_ready",    in_ready,  m_q.size() < DEPTH);
      check_eq("out_valid",   out_valid, m_q.size() > 0);
      check_eq("count",       count,     m_q.size());
      if (m_q.size() > 0)
         check_eq("head", {out_result, out_zero, out_cout, out_overflow, out_tag}, m_q[0]);
      check_eq("sticky_ovf",  sticky_ovf,  m_ovf);
      check_eq("sticky_cout", sticky_cout, m_cout);
      mpush = v && (m_q.size() < DEPTH);
      mpop  = ordy && (m_q.size() > 0);
      @(posedge clk);
      #1;
      if (!rstn) begin
         m_q.delete();
         m_ovf  = 1'b0;
         m_cout = 1'b0;
      end else begin
         if (mpop) void'(m_q.pop_front());
         if (mpush) m_q.push_back({res, zco, tg});
         if (STICKY_EN) begin
            if (mpush && zco[0]) m_ovf = 1'b1;
            else if (clr)        m_ovf = 1'b0;
            if (mpush && zco[1]) m_cout = 1'b1;
            else if (clr)        m_cout = 1'b0;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_result = 32'd0; in_zero = 1'b0; in_cout = 1'b0;
      in_overflow = 1'b0; in_tag = '0; out_ready = 1'b0; sticky_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state, then single entry through the queue
      cycle(1'b0, 32'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 32'h0000_0005, 3'b000, 5'd3, 1'b1, 1'b0, 1'b1);
      check_eq("single_valid", out_valid, 1'b1);
      check_eq("single_res",   out_result, 32'h0000_0005);
      check_eq("single_tag",   out_tag, 5'd3);
      check_eq("single_cnt1",  count, 3'd1);
      cycle(1'b0, 32'd0, 3'b000, 5'd0, 1'b1, 1'b0, 1'b1);
      check_eq("single_cnt0",  count, 3'd0);

      // Fill beyond capacity, then drain in order
      for (int i = 1; i <= 5; i++)
         cycle(1'b1, i, 3'b000, TAG_W'(i), 1'b0, 1'b0, 1'b1);
      check_eq("fill_cnt", count, 3'd4);
      check_eq("fill_rdy", in_ready, 1'b0);
      check_eq("fill_head", out_result, 32'd1);
      for (int i = 0; i < 5; i++)
         cycle(1'b0, 32'd0, 3'b000, 5'd0, 1'b1, 1'b0, 1'b1);
      check_eq("drain_cnt", count, 3'd0);

      // Full queue with simultaneous push request and pop
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 32'h100 + i, 3'b010, 5'd7, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 32'hDEAD, 3'b000, 5'd9, 1'b1, 1'b0, 1'b1);
      check_eq("full_pp_cnt", count, 3'd3);
      check_eq("full_pp_rdy", in_ready, 1'b1);
      check_eq("full_pp_head", out_result, 32'h101);
      for (int i = 0; i < 3; i++)
         cycle(1'b0, 32'd0, 3'b000, 5'd0, 1'b1, 1'b0, 1'b1);

      // Sticky set wins over clear, then clear alone
      cycle(1'b1, 32'h55, 3'b001, 5'd1, 1'b1, 1'b1, 1'b1);
      check_eq("sticky_set_clr", sticky_ovf, STICKY_EN);
      cycle(1'b0, 32'd0, 3'b000, 5'd0, 1'b1, 1'b1, 1'b1);
      check_eq("sticky_clr_only", sticky_ovf, 1'b0);

      // Reset mid-stream with 3 entries queued and a push/pop attempted
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 32'h200 + i, 3'b011, 5'd2, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 32'h999, 3'b011, 5'd4, 1'b1, 1'b0, 1'b0);
      check_eq("rst_cnt",   count, 3'd0);
      check_eq("rst_valid", out_valid, 1'b0);
      check_eq("rst_rdy",   in_ready, 1'b1);
      check_eq("rst_sovf",  sticky_ovf, 1'b0);
      check_eq("rst_scout", sticky_cout, 1'b0);

      // Continuous streaming
      for (int i = 0; i < 100; i++) begin
         cycle(1'b1, 32'h1000 + i, 3'(i), TAG_W'(i), 1'b1, 1'b0, 1'b1);
         check_eq("stream_cnt_le1", count <= 3'd1, 1'b1);
      end
      cycle(1'b0, 32'd0, 3'b000, 5'd0, 1'b1, 1'b0, 1'b1);

      // Random traffic
      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 99) < 60), $urandom, 3'($urandom), TAG_W'($urandom),
               1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 7) == 0),
               1'($urandom_range(0, 59) != 0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_wb_queue.md
ALU_WB_QUEUE -- requirements
Module: alu_wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; a power of two, at least 2.
REQ-002 SHALL have parameter TAG_W, default 5, destination-register tag width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1): producer handshake from the ALU stage.
REQ-006 SHALL have ports in_result (input, 32), in_zero (input, 1), in_cout (input, 1), in_overflow (input, 1) and in_tag (input, TAG_W): the ALU result, its three flags and the destination tag.
REQ-007 SHALL have ports out_valid (output, 1) and out_ready (input, 1): consumer handshake to writeback.
REQ-008 SHALL have ports out_result (output, 32), out_zero, out_cout, out_overflow (output, 1 each) and out_tag (output, TAG_W): the head entry.
REQ-009 SHALL have port count, output, $clog2(DEPTH)+1, number of occupied entries.
REQ-010 SHALL have ports sticky_ovf and sticky_cout (output, 1 each) and sticky_clr (input, 1): accumulated status.

Function
REQ-011 SHALL treat push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-012 SHALL drive in_ready = (count != DEPTH), with no combinational path from out_ready.
REQ-013 SHALL drive out_valid = (count != 0); out_* fields SHALL reflect the head entry, and their values are don't-care while out_valid is 0.
REQ-014 SHALL store each pushed entry {result, zero, cout, overflow, tag} unmodified, in FIFO order.
REQ-015 SHALL make an entry pushed into an empty queue visible on out_* with out_valid=1 in the cycle after the push (latency 1, no bypass).
REQ-016 SHALL update count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-017 SHALL wrap read and write pointers modulo DEPTH and hold no more than DEPTH entries.
REQ-018 SHALL, when full with out_ready=1, pop but not push in that cycle (in_ready is 0); in_ready SHALL rise the next cycle.
REQ-019 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-020 SHALL ignore in_* fields whenever in_valid=0 or in_ready=0.

Reset
REQ-021 SHALL, while rst_n=0 at a rising clk edge, clear pointers and count to 0, drive out_valid=0 and in_ready=1 from the next cycle, and clear both sticky bits.
REQ-022 SHALL discard all queued entries on a reset asserted mid-operation; a push or pop in the reset cycle SHALL have no effect.
REQ-023 SHALL clear storage-array contents on reset only if required by the lint policy; storage contents are not observable.

Configuration
REQ-024 SHALL compile the sticky-flag logic only when macro ALU_WB_STICKY_FLAGS_EN is defined.
REQ-025 SHALL, with the macro defined, set sticky_ovf on any push with in_overflow=1 and set sticky_cout on any push with in_cout=1, and clear both on sticky_clr=1; a set and sticky_clr in the same cycle SHALL leave the bit set.
REQ-026 SHALL, without the macro, tie sticky_ovf and sticky_cout to 0 and ignore sticky_clr.

Structure
REQ-027 SHALL place the entry struct (result, zero, cout, overflow, tag), the default DEPTH and default TAG_W in shared package alu_wb_pkg.
REQ-028 SHALL put the storage array in one sub-module, alu_wb_ram (1 write port, 1 asynchronous read port); pointer, count and flag logic SHALL stay in alu_wb_queue.

Verification
REQ-029 SHALL cover the single-entry case: after reset, push {result=32'h0000_0005, tag=3} with out_ready=1 -> out_valid=1 the next cycle with out_result=5 and out_tag=3; count 1 then 0.
REQ-030 SHALL cover fill and drain: out_ready=0, push 5 entries with results 1..5 -> in_ready=0 after the 4th push, the 5th is not accepted, count=4; then drain -> outputs 1,2,3,4 in order.
REQ-031 SHALL cover the full queue with a simultaneous request: full queue, in_valid=1 and out_ready=1 -> one pop and no push, count=3, in_ready=1 the next cycle.
REQ-032 SHALL cover sticky flags with ALU_WB_STICKY_FLAGS_EN defined: push with in_overflow=1 in the same cycle as sticky_clr=1 -> sticky_ovf=1; sticky_clr alone next cycle -> sticky_ovf=0.
REQ-033 SHALL cover reset mid-stream: 3 entries queued, rst_n=0 for one cycle -> count=0, out_valid=0, in_ready=1 and both sticky bits 0.
REQ-034 SHALL cover continuous streaming: in_valid=1 and out_ready=1 for 100 cycles with incrementing results -> no loss or reorder, and count never exceeds 1.
